// File: rtl/ps2_defs_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, special
// scan codes, default timing parameters and frame-decoding helpers.
package ps2_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATOS  = 2'd1,
      VALIDA = 2'd2
   } estado_t;

   localparam logic [7:0] COD_RUPTURA = 8'hF0;
   localparam logic [7:0] COD_EXT     = 8'hE0;

   localparam int FILTRO_DEF  = 8;
   localparam int TIMEOUT_DEF = 50000;

   // Frame layout {stop, parity, data[7:0]}: stop must be 1 and parity odd.
   function automatic logic trama_ok(input logic [9:0] t);
      return t[9] & (^t[8:0]);
   endfunction

   // True when the frame carries a make code that reaches the consumer.
   function automatic logic entrega(input logic [9:0] t, input logic rup);
      return trama_ok(t) && (t[7:0] != COD_RUPTURA) && (t[7:0] != COD_EXT) && !rup;
   endfunction

endpackage

// File: rtl/filtro_ps2c.sv
// PS/2 pin conditioning: 2-FF synchronizers on both pins, a debounce filter on
// the clock pin and a one-cycle strobe on each filtered falling edge.
module filtro_ps2c #(
   parameter int FILTRO = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2c,
   input  logic ps2d,
   output logic caida,
   output logic dato_s
);

   localparam int CW = (FILTRO > 1) ? $clog2(FILTRO) : 1;

   logic [1:0]    sinc_c;
   logic [1:0]    sinc_d;
   logic          filt;
   logic          filt_q;
   logic [CW-1:0] cuenta;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         sinc_c <= 2'b11;
         sinc_d <= 2'b11;
         filt   <= 1'b1;
         filt_q <= 1'b1;
         cuenta <= '0;
      end else begin
         sinc_c <= {sinc_c[0], ps2c};
         sinc_d <= {sinc_d[0], ps2d};
         filt_q <= filt;
         // Count consecutive samples that disagree with the filtered level.
         if (sinc_c[1] == filt) begin
            cuenta <= '0;
         end else if (cuenta == CW'(FILTRO - 1)) begin
            filt   <= sinc_c[1];
            cuenta <= '0;
         end else begin
            cuenta <= cuenta + 1'b1;
         end
      end
   end

   assign caida  = filt_q & ~filt;
   assign dato_s = sinc_d[1];

endmodule

// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver: frames bits on filtered clock edges, checks parity
// and stop, suppresses break codes and delivers make codes with a watchdog.
module receptor_ps2
   import ps2_defs::*;
#(
   parameter int FILTRO  = FILTRO_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       rx_en,
   output logic [7:0] dato_out,
   output logic       listo,
   output logic       error_trama
);

   localparam int WW = $clog2(TIMEOUT);

   estado_t       estado, estado_sig;
   logic          caida, dato_s;
   logic [3:0]    bits;
   logic [9:0]    trama, trama_sig;
   logic [WW-1:0] perro;
   logic          ruptura, ruptura_sig;
   logic          inicio, fin_trama, expira, carga_dato;

   filtro_ps2c #(.FILTRO(FILTRO)) u_filtro (
      .clk    (clk),
      .rst    (rst),
      .ps2c   (ps2c),
      .ps2d   (ps2d),
      .caida  (caida),
      .dato_s (dato_s)
   );

   assign trama_sig = {dato_s, trama[9:1]};
   assign inicio    = (estado == IDLE) && caida && rx_en && !dato_s;
   assign fin_trama = (estado == DATOS) && caida && (bits == 4'd1);
   // A falling edge arriving on the last allowed cycle still counts as on time.
   assign expira    = (estado == DATOS) && !caida && (perro == WW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) estado <= IDLE;
      else     estado <= estado_sig;
   end

   // NOTE: every combinational output gets a default first so no path
   // through the block leaves a value unassigned, which would infer a latch.
   always_comb begin
      estado_sig = estado;
      case (estado)
         IDLE:    if (inicio) estado_sig = DATOS;
         DATOS:   if (fin_trama)   estado_sig = VALIDA;
                  else if (expira) estado_sig = IDLE;
         VALIDA:  estado_sig = IDLE;
         default: estado_sig = IDLE;
      endcase
   end

   always_comb begin
      listo       = 1'b0;
      error_trama = 1'b0;
      ruptura_sig = ruptura;
      carga_dato  = fin_trama && entrega(trama_sig, ruptura);
      if (estado == VALIDA) begin
         if (!trama_ok(trama)) begin
            error_trama = 1'b1;
            ruptura_sig = 1'b0;
         end else if (trama[7:0] == COD_RUPTURA) begin
            ruptura_sig = 1'b1;
         end else if (trama[7:0] != COD_EXT) begin
            if (ruptura) ruptura_sig = 1'b0;
            else         listo       = 1'b1;
         end
      end else if (expira) begin
         error_trama = 1'b1;
         ruptura_sig = 1'b0;
      end
   end

   // NOTE: the shift register is reset along with the counters so a frame
   // aborted by rst can never leak stale bits into the next decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         bits     <= '0;
         trama    <= '0;
         perro    <= '0;
         ruptura  <= 1'b0;
         dato_out <= '0;
      end else begin
         ruptura <= ruptura_sig;
         if (carga_dato) dato_out <= trama_sig[7:0];
         if (inicio)                            bits <= 4'd10;
         else if ((estado == DATOS) && caida)   bits <= bits - 4'd1;
         if ((estado == DATOS) && caida) trama <= trama_sig;
         if ((estado != DATOS) || caida || expira) perro <= '0;
         else                                      perro <= perro + 1'b1;
      end
   end

endmodule
